// File: rtl/pkg_rv_decode.sv
// pkg_rv_decode: shared decode types for the rv32 execute and writeback stages
package pkg_rv_decode;
  typedef enum logic [1:0] {WB_ALU = 2'd0, WB_MUL = 2'd1, WB_DIV = 2'd2, WB_LD = 2'd3} wb_kind_t;
  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_t;
  localparam logic [31:0] DIV_TMO_DAT = 32'hFFFF_FFFF;
endpackage

// File: rtl/rv_wb_tmo.sv
// rv_wb_tmo: divide-wait timeout counter with clear/enable and expiry flag
module rv_wb_tmo #(
  parameter int DIV_TMO = 40,
  parameter int TMO_W   = 6
) (
  input  logic clk,
  input  logic xreset,
  input  logic rdy,
  input  logic clr,
  input  logic en,
  output logic expire
);
  logic [TMO_W-1:0] cnt_q, cnt_d;
  // clear wins over count; frozen while the pipeline is disabled
  always_comb cnt_d = clr ? '0 : en ? cnt_q + TMO_W'(1) : cnt_q;
  // counter register
  always_ff @(posedge clk)
    if (!xreset) cnt_q <= '0;
    else if (rdy) cnt_q <= cnt_d;
  assign expire = cnt_q == TMO_W'(DIV_TMO - 1);
endmodule

// File: rtl/rv_exwb.sv
// rv_exwb: execute-to-writeback stage with multicycle stall and divide timeout
module rv_exwb
  import pkg_rv_decode::*;
#(
  parameter int DIV_TMO = 40,
  parameter int TMO_W   = 6
) (
  input  logic        clk,
  input  logic        xreset,
  input  logic        rdy,
  input  logic        ex_vld,
  input  logic [1:0]  ex_kind,
  input  logic [4:0]  ex_rd,
  input  logic [31:0] rwdat,
  input  logic [31:0] rwdatx,
  input  logic        cmpl,
  input  logic        mulop,
  input  logic [31:0] ld_data,
  input  logic        ld_vld,
  output logic        stall,
  output logic        wb_we,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_dat,
  output logic        fwd_vld,
  output logic [4:0]  fwd_rd,
  output logic [31:0] fwd_dat,
  output logic        div_err
);
  typedef enum logic [1:0] {IDLE, MUL2, DIVW, LDW} state_t;
  state_t      state_q, state_d;
  wb_kind_t    kind;
  logic [4:0]  rd_q, rd_d, wb_rd_q;
  logic [31:0] dat_d, wb_dat_q;
  logic        done, err_d, tmo_en, expire, wb_we_q, div_err_q;
  assign kind = wb_kind_t'(ex_kind);
  rv_wb_tmo #(.DIV_TMO(DIV_TMO), .TMO_W(TMO_W)) u_tmo (
    .clk(clk), .xreset(xreset), .rdy(rdy), .clr(!tmo_en), .en(tmo_en), .expire(expire)
  );
  // next state, stall decode and completion data; counter runs from the divide issue cycle
  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    done    = 1'b0;
    err_d   = 1'b0;
    tmo_en  = 1'b0;
    rd_d    = rd_q;
    dat_d   = wb_dat_q;
    case (state_q)
      IDLE: if (ex_vld) begin
        rd_d = ex_rd;
        if (mulop || kind == WB_MUL) begin
          stall   = 1'b1;
          state_d = MUL2;
        end else if (kind == WB_DIV) begin
          stall   = 1'b1;
          tmo_en  = 1'b1;
          state_d = DIVW;
        end else if (kind == WB_LD) begin
          stall   = 1'b1;
          state_d = LDW;
        end else begin
          done  = 1'b1;
          dat_d = rwdat;
        end
      end
      MUL2: begin
        done    = 1'b1;
        dat_d   = rwdatx;
        state_d = IDLE;
      end
      DIVW: begin
        stall  = !cmpl && !expire;
        tmo_en = !cmpl && !expire;
        if (cmpl || expire) begin
          done    = 1'b1;
          dat_d   = cmpl ? rwdat : DIV_TMO_DAT;
          err_d   = !cmpl;
          state_d = IDLE;
        end
      end
      LDW: begin
        stall = !ld_vld;
        if (ld_vld) begin
          done    = 1'b1;
          dat_d   = ld_data;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  // state and writeback registers; x0 writes are suppressed but data still lands
  always_ff @(posedge clk)
    if (!xreset) begin
      state_q   <= IDLE;
      rd_q      <= '0;
      wb_we_q   <= 1'b0;
      wb_rd_q   <= '0;
      wb_dat_q  <= '0;
      div_err_q <= 1'b0;
    end else if (rdy) begin
      state_q   <= state_d;
      rd_q      <= rd_d;
      wb_we_q   <= done && rd_d != 5'd0;
      div_err_q <= div_err_q | err_d;
      if (done) begin
        wb_rd_q  <= rd_d;
        wb_dat_q <= dat_d;
      end
    end
  assign wb_we   = wb_we_q;
  assign wb_rd   = wb_rd_q;
  assign wb_dat  = wb_dat_q;
  assign fwd_vld = wb_we_q;
  assign fwd_rd  = wb_rd_q;
  assign fwd_dat = wb_dat_q;
  assign div_err = div_err_q;
endmodule

// File: tb/tb_rv_exwb.sv
// tb_rv_exwb: vector table plus scoreboard bench for the writeback stage
module tb_rv_exwb;
  import pkg_rv_decode::*;
  localparam int TMO = 40;
  logic clk = 0, xreset = 0, rdy = 1, ex_vld = 0, cmpl = 0, mulop = 0, ld_vld = 0;
  logic [1:0] ex_kind = 0;
  logic [4:0] ex_rd = 0;
  logic [31:0] rwdat = 0, rwdatx = 0, ld_data = 0;
  logic stall, wb_we, fwd_vld, div_err;
  logic [4:0] wb_rd, fwd_rd;
  logic [31:0] wb_dat, fwd_dat;
  int errors = 0, checks = 0;
  typedef struct {logic [4:0] rd; logic [31:0] dat;} sb_t;
  typedef struct {logic [4:0] rd; logic [31:0] dat; logic exp_stall; logic exp_we;} vec_t;
  sb_t sbq[$];
  vec_t vt[6];

  always #5 clk = ~clk;

  rv_exwb #(.DIV_TMO(TMO), .TMO_W(6)) dut (
    .clk(clk), .xreset(xreset), .rdy(rdy), .ex_vld(ex_vld), .ex_kind(ex_kind), .ex_rd(ex_rd),
    .rwdat(rwdat), .rwdatx(rwdatx), .cmpl(cmpl), .mulop(mulop), .ld_data(ld_data), .ld_vld(ld_vld),
    .stall(stall), .wb_we(wb_we), .wb_rd(wb_rd), .wb_dat(wb_dat), .fwd_vld(fwd_vld),
    .fwd_rd(fwd_rd), .fwd_dat(fwd_dat), .div_err(div_err)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [4:0] r, input logic [31:0] d);
    sb_t e;
    e.rd = r;
    e.dat = d;
    sbq.push_back(e);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_we"}, wb_we, 0);
    chk({tag, "_rd"}, wb_rd, 0);
    chk({tag, "_dat"}, wb_dat, 0);
    chk({tag, "_fvld"}, fwd_vld, 0);
    chk({tag, "_frd"}, fwd_rd, 0);
    chk({tag, "_fdat"}, fwd_dat, 0);
    chk({tag, "_err"}, div_err, 0);
  endtask

  // every write pulse after an enabled edge must match the oldest expected completion
  always @(posedge clk) begin
    logic en;
    sb_t e;
    en = rdy && xreset;
    #1;
    if (en && wb_we) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: rd=%0d dat=%h with no completion expected", wb_rd, wb_dat);
      end else begin
        e = sbq.pop_front();
        chk("sb_rd", wb_rd, e.rd);
        chk("sb_dat", wb_dat, e.dat);
        chk("sb_fwd_vld", fwd_vld, 1);
        chk("sb_fwd_rd", fwd_rd, e.rd);
        chk("sb_fwd_dat", fwd_dat, e.dat);
      end
    end
  end

  task automatic do_mul(input logic [1:0] k, input logic m, input logic [4:0] r, input logic [31:0] d);
    ex_vld = 1; ex_kind = k; mulop = m; ex_rd = r; rwdat = ~d; rwdatx = 0;
    #1;
    chk("mul_stall_n", stall, 1);
    cyc();
    rwdatx = d;
    #1;
    chk("mul_stall_n1", stall, 0);
    chk("mul_we_n1", wb_we, 0);
    if (r != 0) push(r, d);
    cyc();
    ex_vld = 0; mulop = 0;
    chk("mul_we", wb_we, r != 0);
    chk("mul_dat", wb_dat, d);
  endtask

  task automatic run_div(input logic [4:0] r, input int cat, input logic [31:0] d);
    int last;
    logic [31:0] ed;
    last = (cat < TMO) ? cat : TMO - 1;
    ed = (cat == last) ? d : 32'hFFFF_FFFF;
    ex_vld = 1; ex_kind = WB_DIV; mulop = 0; ex_rd = r; rwdat = 0; cmpl = 0;
    #1;
    chk("div_stall_issue", stall, 1);
    cyc();
    for (int k = 1; k < last; k++) begin
      #1;
      chk("div_stall_wait", stall, 1);
      cyc();
    end
    if (cat == last) begin
      cmpl = 1;
      rwdat = d;
    end
    #1;
    chk("div_stall_end", stall, 0);
    if (r != 0) push(r, ed);
    cyc();
    cmpl = 0; ex_vld = 0;
    chk("div_we", wb_we, r != 0);
    chk("div_dat", wb_dat, ed);
    chk("div_err", div_err, cat != last);
  endtask

  task automatic run_ld(input logic [4:0] r, input int lat, input logic [31:0] d);
    ex_vld = 1; ex_kind = WB_LD; mulop = 0; ex_rd = r; ld_vld = 0;
    #1;
    chk("ld_stall_issue", stall, 1);
    cyc();
    for (int k = 1; k < lat; k++) begin
      #1;
      chk("ld_stall_wait", stall, 1);
      cyc();
    end
    ld_vld = 1; ld_data = d;
    #1;
    chk("ld_stall_end", stall, 0);
    if (r != 0) push(r, d);
    cyc();
    ld_vld = 0; ex_vld = 0;
    chk("ld_we", wb_we, r != 0);
    chk("ld_dat", wb_dat, d);
  endtask

  initial begin
    vt[0] = '{5'd5, 32'h1234_5678, 1'b0, 1'b1};
    vt[1] = '{5'd31, 32'hA5A5_0001, 1'b0, 1'b1};
    vt[2] = '{5'd0, 32'h0BAD_F00D, 1'b0, 1'b0};
    vt[3] = '{5'd1, 32'hFFFF_FFFE, 1'b0, 1'b1};
    vt[4] = '{5'd17, 32'h0000_0000, 1'b0, 1'b1};
    vt[5] = '{5'd12, 32'h8000_0000, 1'b0, 1'b1};
    repeat (2) cyc();
    chk("rst_stall", stall, 0);
    chk_zero("rst");
    xreset = 1;
    for (int i = 0; i < 6; i++) begin
      ex_vld = 1; ex_kind = WB_ALU; mulop = 0; ex_rd = vt[i].rd; rwdat = vt[i].dat;
      #1;
      chk("alu_stall", stall, vt[i].exp_stall);
      if (vt[i].exp_we) push(vt[i].rd, vt[i].dat);
      cyc();
      chk("alu_we", wb_we, vt[i].exp_we);
      chk("alu_dat", wb_dat, vt[i].dat);
      chk("alu_rd", wb_rd, vt[i].rd);
    end
    ex_vld = 0;
    cyc();
    chk("we_pulse", wb_we, 0);
    cmpl = 1; ld_vld = 1;
    cyc();
    cmpl = 0; ld_vld = 0;
    chk("idle_strobe_ignored", wb_we, 0);
    do_mul(WB_ALU, 1, 5'd7, 32'hDEAD_BEEF);
    do_mul(WB_MUL, 0, 5'd8, 32'h0000_CAFE);
    do_mul(WB_LD, 1, 5'd9, 32'h1357_9BDF);
    run_div(5'd3, 17, 32'd42);
    run_ld(5'd0, 3, 32'h7777_0000);
    run_ld(5'd10, 1, 32'h5555_AAAA);
    run_div(5'd4, 99, 32'd0);
    ex_vld = 1; ex_kind = WB_ALU; ex_rd = 5'd13; rwdat = 32'd1;
    push(5'd13, 32'd1);
    cyc();
    ex_vld = 0;
    chk("div_err_sticky", div_err, 1);
    xreset = 0;
    cyc();
    xreset = 1;
    chk("rst_clears_err", div_err, 0);
    run_div(5'd2, TMO - 1, 32'd99);
    ex_vld = 1; ex_kind = WB_DIV; ex_rd = 5'd6; cmpl = 0;
    cyc();
    for (int k = 1; k < 10; k++) cyc();
    rdy = 0;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("frz_stall", stall, 1);
      cyc();
    end
    rdy = 1;
    for (int k = 14; k < TMO + 3; k++) begin
      #1;
      chk("frz_wait", stall, 1);
      cyc();
    end
    #1;
    chk("frz_tmo_stall", stall, 0);
    push(5'd6, 32'hFFFF_FFFF);
    cyc();
    ex_vld = 0;
    chk("frz_we", wb_we, 1);
    chk("frz_err", div_err, 1);
    ex_vld = 1; ex_kind = WB_DIV; ex_rd = 5'd11;
    repeat (5) cyc();
    rdy = 0;
    repeat (2) cyc();
    xreset = 0; ex_vld = 0;
    cyc();
    chk("mid_rst_stall", stall, 0);
    chk_zero("mid_rst");
    xreset = 1; rdy = 1; cmpl = 1;
    cyc();
    cmpl = 0;
    chk("mid_rst_no_write", wb_we, 0);
    ex_vld = 1; ex_kind = WB_ALU; ex_rd = 5'd14; rwdat = 32'h0F0F_1234;
    #1;
    chk("post_rst_stall", stall, 0);
    push(5'd14, 32'h0F0F_1234);
    cyc();
    ex_vld = 0;
    chk("post_rst_we", wb_we, 1);
    cyc();
    chk("sb_empty", sbq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
